// File: rtl/instr_coordinator_if.sv
// Instruction type shared by the coordinator and its neighbours, plus the
// bundle of buffer-side and execution-unit-side signals around the coordinator.
package instr_coordinator_pkg;
    typedef struct packed {
        logic [7:0]  opcode;
        logic [23:0] operand;
    } instr_type;

    localparam instr_type INIT_INSTR = '0;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_HALT,
        CLS_WEIGHT,
        CLS_MATMUL,
        CLS_ACT,
        CLS_ILLEGAL
    } instr_class_e;
endpackage

interface instr_coordinator_if #(
    parameter int CNT_WIDTH = 32
);
    import instr_coordinator_pkg::*;

    logic                 enable;
    instr_type            instr_in;
    logic                 instr_read;
    logic                 instr_busy;
    instr_type            weight_instr;
    logic                 weight_en;
    logic                 weight_busy;
    instr_type            matmul_instr;
    logic                 matmul_en;
    logic                 matmul_busy;
    instr_type            act_instr;
    logic                 act_en;
    logic                 act_busy;
    logic                 resume;
    logic                 halted;
    logic                 illegal_op;
    logic [CNT_WIDTH-1:0] issue_count;
    logic [CNT_WIDTH-1:0] stall_count;

    // The coordinator itself is the master; buffer and units form the slave side.
    modport master (
        input  enable, instr_in, instr_read, weight_busy, matmul_busy, act_busy, resume,
        output instr_busy, weight_instr, weight_en, matmul_instr, matmul_en,
               act_instr, act_en, halted, illegal_op, issue_count, stall_count
    );

    modport slave (
        output enable, instr_in, instr_read, weight_busy, matmul_busy, act_busy, resume,
        input  instr_busy, weight_instr, weight_en, matmul_instr, matmul_en,
               act_instr, act_en, halted, illegal_op, issue_count, stall_count
    );
endinterface

// File: rtl/instr_coordinator.sv
// Decodes one instruction at a time, checks unit hazards and issues it to the
// weight loader, matrix-multiply or activation unit; handles HALT draining.
module instr_coordinator
    import instr_coordinator_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_coordinator_if.master  bus
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_e;

    state_e               stateQ, stateD;
    instr_type            holdQ, holdD;
    instr_class_e         holdClsQ, holdClsD;
    logic                 holdValidQ, holdValidD;
    logic                 illegalQ, illegalD;
    logic                 haltedQ;
    logic [CNT_WIDTH-1:0] issueCntQ, issueCntD;
    logic [CNT_WIDTH-1:0] stallCntQ, stallCntD;
    instr_type            weightInstrQ, matmulInstrQ, actInstrQ;
    logic                 weightIssQ, matmulIssQ, actIssQ;

    instr_class_e         inCls;
    logic                 weightEff, matmulEff, actEff;
    logic                 ready, issueNow, stallNow, accept, allIdle, busyOut;
    logic                 weightEn, matmulEn, actEn;

    always_comb begin
        inCls = CLS_ILLEGAL;
        if (bus.instr_in.opcode == 8'h00)              inCls = CLS_NOP;
        else if (bus.instr_in.opcode == 8'hFF)         inCls = CLS_HALT;
        else if (bus.instr_in.opcode[7:3] == 5'b00001) inCls = CLS_WEIGHT;
        else if (bus.instr_in.opcode[7:3] == 5'b00100) inCls = CLS_MATMUL;
        else if (bus.instr_in.opcode[7:4] == 4'b1000)  inCls = CLS_ACT;
    end

    // A unit issued last cycle may not have raised its busy yet, so it counts as busy.
    assign weightEff = bus.weight_busy | weightIssQ;
    assign matmulEff = bus.matmul_busy | matmulIssQ;
    assign actEff    = bus.act_busy    | actIssQ;

    always_comb begin
        ready = 1'b0;
        case (holdClsQ)
            CLS_WEIGHT: ready = !weightEff;
            CLS_MATMUL: ready = !matmulEff & !weightEff;
            CLS_ACT:    ready = !actEff & !matmulEff;
            default:    ready = 1'b0;
        endcase
    end

    assign issueNow = bus.enable & holdValidQ & ready;
    assign stallNow = bus.enable & holdValidQ & !ready;
    assign weightEn = issueNow & (holdClsQ == CLS_WEIGHT);
    assign matmulEn = issueNow & (holdClsQ == CLS_MATMUL);
    assign actEn    = issueNow & (holdClsQ == CLS_ACT);
    assign busyOut  = !bus.enable | (holdValidQ & !issueNow) | (stateQ != ST_RUN);
    assign accept   = bus.enable & bus.instr_read & !busyOut;
    assign allIdle  = !weightEff & !matmulEff & !actEff & !holdValidQ;

    // Issue clears the hold slot first so a same-cycle accept can refill it.
    always_comb begin
        stateD     = stateQ;
        holdD      = holdQ;
        holdClsD   = holdClsQ;
        holdValidD = holdValidQ;
        illegalD   = illegalQ;
        issueCntD  = issueCntQ;
        stallCntD  = stallCntQ;
        if (bus.enable) begin
            if (issueNow) begin
                holdValidD = 1'b0;
                issueCntD  = issueCntQ + CNT_WIDTH'(1);
            end
            if (stallNow) begin
                stallCntD = stallCntQ + CNT_WIDTH'(1);
            end
            if (accept) begin
                case (inCls)
                    CLS_NOP:     ;
                    CLS_HALT:    stateD = ST_DRAIN;
                    CLS_ILLEGAL: illegalD = 1'b1;
                    default: begin
                        holdD      = bus.instr_in;
                        holdClsD   = inCls;
                        holdValidD = 1'b1;
                    end
                endcase
            end
            case (stateQ)
                ST_DRAIN:  if (allIdle) stateD = ST_HALTED;
                ST_HALTED: if (bus.resume) stateD = ST_RUN;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ       <= ST_RUN;
            holdQ        <= INIT_INSTR;
            holdClsQ     <= CLS_NOP;
            holdValidQ   <= 1'b0;
            illegalQ     <= 1'b0;
            haltedQ      <= 1'b0;
            issueCntQ    <= '0;
            stallCntQ    <= '0;
            weightInstrQ <= INIT_INSTR;
            matmulInstrQ <= INIT_INSTR;
            actInstrQ    <= INIT_INSTR;
            weightIssQ   <= 1'b0;
            matmulIssQ   <= 1'b0;
            actIssQ      <= 1'b0;
        end else begin
            stateQ       <= stateD;
            holdQ        <= holdD;
            holdClsQ     <= holdClsD;
            holdValidQ   <= holdValidD;
            illegalQ     <= illegalD;
            haltedQ      <= (stateD == ST_HALTED);
            issueCntQ    <= issueCntD;
            stallCntQ    <= stallCntD;
            weightInstrQ <= bus.weight_instr;
            matmulInstrQ <= bus.matmul_instr;
            actInstrQ    <= bus.act_instr;
            weightIssQ   <= weightEn;
            matmulIssQ   <= matmulEn;
            actIssQ      <= actEn;
        end
    end

    assign bus.instr_busy   = busyOut;
    assign bus.weight_en    = weightEn;
    assign bus.matmul_en    = matmulEn;
    assign bus.act_en       = actEn;
    assign bus.weight_instr = weightEn ? holdQ : weightInstrQ;
    assign bus.matmul_instr = matmulEn ? holdQ : matmulInstrQ;
    assign bus.act_instr    = actEn    ? holdQ : actInstrQ;
    assign bus.halted       = haltedQ;
    assign bus.illegal_op   = illegalQ;
    assign bus.issue_count  = issueCntQ;
    assign bus.stall_count  = stallCntQ;

endmodule

// File: tb/tb_instr_coordinator.sv
// Directed bench for instr_coordinator: hazards, stalls, illegal opcodes,
// HALT/resume, enable gating and asynchronous reset, checked against hand values.
module tb_instr_coordinator;
    import instr_coordinator_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    localparam instr_type NONE = INIT_INSTR;
    localparam instr_type W1   = {8'h08, 24'h000011};
    localparam instr_type M1   = {8'h20, 24'h000022};
    localparam instr_type A1   = {8'h80, 24'h000033};
    localparam instr_type M2   = {8'h27, 24'h000044};
    localparam instr_type BAD  = {8'h55, 24'h000055};
    localparam instr_type NOP  = {8'h00, 24'h000066};
    localparam instr_type HALT = {8'hFF, 24'h000077};
    localparam instr_type W3   = {8'h0F, 24'h000088};
    localparam instr_type M3   = {8'h21, 24'h000099};
    localparam instr_type A2   = {8'h8F, 24'h0000AA};

    instr_coordinator_if #(.CNT_WIDTH(32)) bus ();

    instr_coordinator #(.CNT_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkEns(input string tag, input logic w, input logic m, input logic a);
        checkOutput({tag, ".weight_en"}, 32'(bus.weight_en), 32'(w));
        checkOutput({tag, ".matmul_en"}, 32'(bus.matmul_en), 32'(m));
        checkOutput({tag, ".act_en"},    32'(bus.act_en),    32'(a));
    endtask

    task automatic checkCounts(input string tag, input int iss, input int stl);
        checkOutput({tag, ".issue_count"}, bus.issue_count, 32'(iss));
        checkOutput({tag, ".stall_count"}, bus.stall_count, 32'(stl));
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Drives inputs just after the edge, then waits to mid-cycle for checking.
    task automatic applyStimulus(input logic rd, input instr_type ins, input logic wb,
                                 input logic mb, input logic ab, input logic en,
                                 input logic res);
        bus.instr_read  = rd;
        bus.instr_in    = ins;
        bus.weight_busy = wb;
        bus.matmul_busy = mb;
        bus.act_busy    = ab;
        bus.enable      = en;
        bus.resume      = res;
        #4;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        bus.instr_read  = 1'b0;
        bus.instr_in    = NONE;
        bus.weight_busy = 1'b0;
        bus.matmul_busy = 1'b0;
        bus.act_busy    = 1'b0;
        bus.enable      = 1'b1;
        bus.resume      = 1'b0;

        nextCycle();
        applyStimulus(1'b0, NONE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("rst.instr_busy", 32'(bus.instr_busy), 32'd0);
        checkOutput("rst.halted", 32'(bus.halted), 32'd0);
        checkOutput("rst.illegal_op", 32'(bus.illegal_op), 32'd0);
        checkOutput("rst.weight_instr", bus.weight_instr, NONE);
        checkEns("rst", 1'b0, 1'b0, 1'b0);
        checkCounts("rst", 0, 0);

        // Cycle 0: W1 offered, accepted at the end of this cycle.
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b1, W1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkEns("c0", 1'b0, 1'b0, 1'b0);
        checkOutput("c0.instr_busy", 32'(bus.instr_busy), 32'd0);

        // Cycle 1: W1 issues while M1 is accepted behind it.
        nextCycle();
        applyStimulus(1'b1, M1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkEns("c1", 1'b1, 1'b0, 1'b0);
        checkOutput("c1.weight_instr", bus.weight_instr, W1);
        checkOutput("c1.instr_busy", 32'(bus.instr_busy), 32'd0);

        // Cycle 2: M1 stalls on the weight shadow.
        nextCycle();
        applyStimulus(1'b1, M1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkEns("c2", 1'b0, 1'b0, 1'b0);
        checkOutput("c2.instr_busy", 32'(bus.instr_busy), 32'd1);
        checkCounts("c2", 1, 0);

        nextCycle();
        applyStimulus(1'b1, A1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkEns("c3", 1'b0, 1'b1, 1'b0);
        checkOutput("c3.matmul_instr", bus.matmul_instr, M1);
        checkOutput("c3.instr_busy", 32'(bus.instr_busy), 32'd0);
        checkCounts("c3", 1, 1);

        nextCycle();
        applyStimulus(1'b0, NONE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkEns("c4", 1'b0, 1'b0, 1'b0);
        checkOutput("c4.instr_busy", 32'(bus.instr_busy), 32'd1);
        checkCounts("c4", 2, 1);

        nextCycle();
        applyStimulus(1'b0, NONE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkEns("c5", 1'b0, 1'b0, 1'b1);
        checkOutput("c5.act_instr", bus.act_instr, A1);
        checkCounts("c5", 2, 2);

        nextCycle();
        applyStimulus(1'b0, NONE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkEns("c6", 1'b0, 1'b0, 1'b0);
        checkOutput("c6.weight_instr", bus.weight_instr, W1);
        checkCounts("c6", 3, 2);

        // Cycle 7: M2 accepted while the weight loader is busy.
        nextCycle();
        applyStimulus(1'b1, M2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("c7.instr_busy", 32'(bus.instr_busy), 32'd0);
        for (int i = 8; i <= 12; i++) begin
            nextCycle();
            applyStimulus(1'b0, NONE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            checkEns($sformatf("c%0d", i), 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("c%0d.instr_busy", i), 32'(bus.instr_busy), 32'd1);
        end
        nextCycle();
        applyStimulus(1'b0, NONE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkEns("c13", 1'b0, 1'b1, 1'b0);
        checkOutput("c13.matmul_instr", bus.matmul_instr, M2);
        checkCounts("c13", 3, 7);

        // Cycles 14-16: illegal opcode then NOP; neither is held or issued.
        nextCycle();
        applyStimulus(1'b1, BAD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("c14.illegal_op", 32'(bus.illegal_op), 32'd0);
        checkCounts("c14", 4, 7);
        nextCycle();
        applyStimulus(1'b1, NOP, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("c15.illegal_op", 32'(bus.illegal_op), 32'd1);
        checkOutput("c15.instr_busy", 32'(bus.instr_busy), 32'd0);
        checkEns("c15", 1'b0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, NONE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("c16.illegal_op", 32'(bus.illegal_op), 32'd1);
        checkOutput("c16.instr_busy", 32'(bus.instr_busy), 32'd0);
        checkEns("c16", 1'b0, 1'b0, 1'b0);
        checkCounts("c16", 4, 7);

        // Cycle 17: HALT accepted while the matmul unit is busy.
        nextCycle();
        applyStimulus(1'b1, HALT, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("c17.instr_busy", 32'(bus.instr_busy), 32'd0);
        for (int i = 18; i <= 20; i++) begin
            nextCycle();
            applyStimulus(1'b0, NONE, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("c%0d.instr_busy", i), 32'(bus.instr_busy), 32'd1);
            checkOutput($sformatf("c%0d.halted", i), 32'(bus.halted), 32'd0);
        end
        nextCycle();
        applyStimulus(1'b0, NONE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("c21.halted", 32'(bus.halted), 32'd0);
        checkOutput("c21.instr_busy", 32'(bus.instr_busy), 32'd1);
        nextCycle();
        applyStimulus(1'b1, W3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("c22.halted", 32'(bus.halted), 32'd1);
        checkOutput("c22.instr_busy", 32'(bus.instr_busy), 32'd1);
        nextCycle();
        applyStimulus(1'b1, W3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("c23.halted", 32'(bus.halted), 32'd1);
        checkEns("c23", 1'b0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, W3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("c24.halted", 32'(bus.halted), 32'd0);
        checkOutput("c24.instr_busy", 32'(bus.instr_busy), 32'd0);
        checkEns("c24", 1'b0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, NONE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkEns("c25", 1'b1, 1'b0, 1'b0);
        checkOutput("c25.weight_instr", bus.weight_instr, W3);
        checkCounts("c25", 4, 7);

        // Cycles 26-31: M3 held and ready, but enable is low for four cycles.
        nextCycle();
        applyStimulus(1'b1, M3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("c26.instr_busy", 32'(bus.instr_busy), 32'd0);
        checkCounts("c26", 5, 7);
        for (int i = 27; i <= 30; i++) begin
            nextCycle();
            applyStimulus(1'b0, NONE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            checkEns($sformatf("c%0d", i), 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("c%0d.instr_busy", i), 32'(bus.instr_busy), 32'd1);
            checkCounts($sformatf("c%0d", i), 5, 7);
        end
        nextCycle();
        applyStimulus(1'b0, NONE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkEns("c31", 1'b0, 1'b1, 1'b0);
        checkOutput("c31.matmul_instr", bus.matmul_instr, M3);

        // Cycles 32-33: A2 held behind a busy activation unit, then async reset.
        nextCycle();
        applyStimulus(1'b1, A2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkEns("c32", 1'b0, 1'b0, 1'b0);
        checkCounts("c32", 6, 7);
        nextCycle();
        applyStimulus(1'b0, NONE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkEns("c33", 1'b0, 1'b0, 1'b0);
        checkOutput("c33.instr_busy", 32'(bus.instr_busy), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("arst.instr_busy", 32'(bus.instr_busy), 32'd0);
        checkOutput("arst.illegal_op", 32'(bus.illegal_op), 32'd0);
        checkOutput("arst.matmul_instr", bus.matmul_instr, NONE);
        checkOutput("arst.weight_instr", bus.weight_instr, NONE);
        checkCounts("arst", 0, 0);
        bus.act_busy = 1'b0;
        #1;
        checkEns("arst", 1'b0, 1'b0, 1'b0);
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b0, NONE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkEns("post0", 1'b0, 1'b0, 1'b0);
        checkOutput("post0.instr_busy", 32'(bus.instr_busy), 32'd0);
        nextCycle();
        applyStimulus(1'b0, NONE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkEns("post1", 1'b0, 1'b0, 1'b0);
        checkOutput("post1.act_instr", bus.act_instr, NONE);
        checkCounts("post1", 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
